// File: rtl/matvec_ntt_mac_pkg.sv
// Shared ML-KEM types and constants for the NTT-domain matrix-vector MAC.
// Holds the coefficient/vector types, pipeline stage records and the gamma table.
package matvec_ntt_mac_pkg;

  localparam int unsigned ML_KEM_K     = 2;
  localparam int unsigned ML_KEM_Q     = 3329;
  localparam int unsigned ML_KEM_LEN_Q = 12;

  typedef logic [ML_KEM_LEN_Q-1:0] coef_t;
  typedef coef_t [255:0]           poly_t;
  typedef poly_t [ML_KEM_K-1:0]    polyvec_t;
  typedef polyvec_t [ML_KEM_K-1:0] polymat_t;
  typedef coef_t [127:0]           gamma_tab_t;

  localparam int unsigned IDX_W = (ML_KEM_K > 1) ? $clog2(ML_KEM_K) : 1;
  typedef logic [IDX_W-1:0] idx_t;
  typedef logic [6:0]       pair_t;

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN} state_e;

  typedef struct packed {
    logic        vld;
    logic [23:0] p00;
    logic [23:0] p11;
    logic [23:0] p01;
    logic [23:0] p10;
    coef_t       gamma;
    idx_t        i;
    pair_t       k;
  } s1_t;

  typedef struct packed {
    logic        vld;
    coef_t       r11;
    coef_t       c1;
    logic [23:0] p00;
    coef_t       gamma;
    idx_t        i;
    pair_t       k;
  } s2_t;

  typedef struct packed {
    logic  vld;
    coef_t c0;
    coef_t c1;
    idx_t  i;
    pair_t k;
  } s3_t;

  // floor(2^36/q): the quotient estimate is at most one low for any 25-bit input
  localparam int unsigned BARRETT_SHIFT = 36;
  localparam logic [24:0] BARRETT_M = 25'((64'd1 << BARRETT_SHIFT) / 64'(ML_KEM_Q));

  function automatic coef_t gamma_of(input int unsigned k);
    int unsigned brv;
    int unsigned e;
    int unsigned g;
    brv = 0;
    for (int unsigned b = 0; b < 7; b++) begin
      if (((k >> b) & 1) != 0) brv = brv | (1 << (6 - b));
    end
    e = 2 * brv + 1;
    g = 1;
    for (int unsigned n = 0; n < e; n++) g = (g * 17) % ML_KEM_Q;
    return coef_t'(g);
  endfunction

  function automatic gamma_tab_t gen_gamma();
    gamma_tab_t t;
    for (int unsigned k = 0; k < 128; k++) t[k] = gamma_of(k);
    return t;
  endfunction

  localparam gamma_tab_t ML_KEM_GAMMA = gen_gamma();

endpackage

// File: rtl/matvec_ntt_mac_mod_q_reduce.sv
// Combinational Barrett reduction of a 25-bit value into [0,q).
module mod_q_reduce
  import matvec_ntt_mac_pkg::*;
(
  input  logic [24:0] x_i,
  output coef_t       r_o
);

  logic [49:0] prod;
  logic [13:0] qt;
  logic [12:0] rem;

  // x - qt*q lies in [0,2q) < 2^13, so only the low 13 bits need computing
  always_comb begin
    prod = 50'(x_i) * 50'(BARRETT_M);
    qt   = 14'(prod >> BARRETT_SHIFT);
    rem  = x_i[12:0] - 13'(qt * 14'(ML_KEM_Q));
    r_o  = (rem >= 13'(ML_KEM_Q)) ? coef_t'(rem - 13'(ML_KEM_Q)) : coef_t'(rem);
  end

endmodule

// File: rtl/matvec_ntt_mac.sv
// NTT-domain t_hat = A_hat o s_hat + e_hat with a 3-stage MultiplyNTTs pipeline
// issuing one coefficient pair per cycle, accumulating in place in the output register.
module matvec_ntt_mac
  import matvec_ntt_mac_pkg::*;
(
  input  logic     clk_i,
  input  logic     rst_i,
  input  logic     run_i,
  input  logic     transpose_i,
  input  polymat_t polymat_A_i,
  input  polyvec_t polyvec_s_i,
  input  polyvec_t polyvec_e_i,
  output logic     busy_o,
  output logic     done_o,
  output polyvec_t polyvec_t_o
);

  localparam idx_t        LAST_IDX = idx_t'(ML_KEM_K - 1);
  localparam logic [12:0] Q13      = 13'(ML_KEM_Q);

  state_e     state_q, state_d;
  idx_t       i_q, i_d, j_q, j_d;
  pair_t      k_q, k_d;
  logic       trans_q, trans_d;
  logic [1:0] drain_q, drain_d;
  logic       done_q, done_d;
  logic       accept, issue;

  s1_t        s1_q, s1_d;
  s2_t        s2_q, s2_d;
  s3_t        s3_q, s3_d;
  polyvec_t   acc_q, acc_d;

  poly_t       a_sel, b_sel;
  coef_t       a0, a1, b0, b1;
  logic [24:0] x_r11, x_c1, x_c0;
  coef_t       r11, c1, c0;
  logic [12:0] sum0, sum1;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      i_q     <= '0;
      j_q     <= '0;
      k_q     <= '0;
      trans_q <= 1'b0;
      drain_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
      k_q     <= k_d;
      trans_q <= trans_d;
      drain_q <= drain_d;
      done_q  <= done_d;
    end
  end

  // run_i during the done pulse is ignored so done and acceptance never coincide
  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    j_d     = j_q;
    k_d     = k_q;
    trans_d = trans_q;
    drain_d = drain_q;
    done_d  = 1'b0;
    accept  = 1'b0;
    issue   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (run_i && !done_q) begin
          accept  = 1'b1;
          trans_d = transpose_i;
          i_d     = '0;
          j_d     = '0;
          k_d     = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        issue = 1'b1;
        k_d   = k_q + 7'd1;
        if (k_q == 7'd127) begin
          if (j_q == LAST_IDX) begin
            j_d = '0;
            if (i_q == LAST_IDX) begin
              drain_d = '0;
              state_d = ST_DRAIN;
            end else begin
              i_d = i_q + idx_t'(1);
            end
          end else begin
            j_d = j_q + idx_t'(1);
          end
        end
      end
      ST_DRAIN: begin
        drain_d = drain_q + 2'd1;
        if (drain_q == 2'd3) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy_o      = (state_q != ST_IDLE);
    done_o      = done_q;
    polyvec_t_o = acc_q;
  end

  always_comb begin
    a_sel = trans_q ? polymat_A_i[j_q][i_q] : polymat_A_i[i_q][j_q];
    b_sel = polyvec_s_i[j_q];
    a0    = a_sel[{k_q, 1'b0}];
    a1    = a_sel[{k_q, 1'b1}];
    b0    = b_sel[{k_q, 1'b0}];
    b1    = b_sel[{k_q, 1'b1}];
    s1_d.vld   = issue;
    s1_d.p00   = 24'(a0) * 24'(b0);
    s1_d.p11   = 24'(a1) * 24'(b1);
    s1_d.p01   = 24'(a0) * 24'(b1);
    s1_d.p10   = 24'(a1) * 24'(b0);
    s1_d.gamma = ML_KEM_GAMMA[k_q];
    s1_d.i     = i_q;
    s1_d.k     = k_q;
  end

  always_comb begin
    x_r11 = 25'(s1_q.p11);
    x_c1  = 25'(s1_q.p01) + 25'(s1_q.p10);
    x_c0  = 25'(s2_q.p00) + 25'(s2_q.r11) * 25'(s2_q.gamma);
  end

  mod_q_reduce u_red_r11 (.x_i(x_r11), .r_o(r11));
  mod_q_reduce u_red_c1  (.x_i(x_c1),  .r_o(c1));
  mod_q_reduce u_red_c0  (.x_i(x_c0),  .r_o(c0));

  always_comb begin
    s2_d.vld   = s1_q.vld;
    s2_d.r11   = r11;
    s2_d.c1    = c1;
    s2_d.p00   = s1_q.p00;
    s2_d.gamma = s1_q.gamma;
    s2_d.i     = s1_q.i;
    s2_d.k     = s1_q.k;
    s3_d.vld   = s2_q.vld;
    s3_d.c0    = c0;
    s3_d.c1    = s2_q.c1;
    s3_d.i     = s2_q.i;
    s3_d.k     = s2_q.k;
  end

  // a coefficient is revisited only 128 issues later, so no forwarding into this stage
  always_comb begin
    acc_d = acc_q;
    sum0  = 13'(acc_q[s3_q.i][{s3_q.k, 1'b0}]) + 13'(s3_q.c0);
    sum1  = 13'(acc_q[s3_q.i][{s3_q.k, 1'b1}]) + 13'(s3_q.c1);
    if (accept) begin
      acc_d = polyvec_e_i;
    end else if (s3_q.vld) begin
      acc_d[s3_q.i][{s3_q.k, 1'b0}] = (sum0 >= Q13) ? coef_t'(sum0 - Q13) : coef_t'(sum0);
      acc_d[s3_q.i][{s3_q.k, 1'b1}] = (sum1 >= Q13) ? coef_t'(sum1 - Q13) : coef_t'(sum1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s1_q  <= '0;
      s2_q  <= '0;
      s3_q  <= '0;
      acc_q <= '0;
    end else begin
      s1_q  <= s1_d;
      s2_q  <= s2_d;
      s3_q  <= s3_d;
      acc_q <= acc_d;
    end
  end

endmodule

// File: tb/tb_matvec_ntt_mac.sv
// Randomised self-checking bench for matvec_ntt_mac against a plain-arithmetic
// MultiplyNTTs matrix-vector model.
module tb_matvec_ntt_mac;
  import matvec_ntt_mac_pkg::*;

  localparam int K = 2;
  localparam int Q = 3329;
  localparam int LAT = K * K * 128 + 4;

  logic     clk_i = 1'b0;
  logic     rst_i;
  logic     run_i;
  logic     transpose_i;
  polymat_t a_in;
  polyvec_t s_in;
  polyvec_t e_in;
  logic     busy_o;
  logic     done_o;
  polyvec_t t_out;

  always #5 clk_i = ~clk_i;

  matvec_ntt_mac dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .run_i       (run_i),
    .transpose_i (transpose_i),
    .polymat_A_i (a_in),
    .polyvec_s_i (s_in),
    .polyvec_e_i (e_in),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .polyvec_t_o (t_out)
  );

  int tA[K][K][256];
  int ts[K][256];
  int te[K][256];
  int exp_t[K][256];
  int gam[128];
  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input longint got, input longint want);
    n_cmp++;
    if (got != want) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, want);
    end
  endtask

  task automatic clear_vectors();
    for (int i = 0; i < K; i++)
      for (int c = 0; c < 256; c++) begin
        ts[i][c] = 0;
        te[i][c] = 0;
        for (int j = 0; j < K; j++) tA[i][j][c] = 0;
      end
  endtask

  task automatic fill_vectors(input bit worst);
    for (int i = 0; i < K; i++)
      for (int c = 0; c < 256; c++) begin
        ts[i][c] = worst ? Q - 1 : int'($urandom_range(0, Q - 1));
        te[i][c] = worst ? Q - 1 : int'($urandom_range(0, Q - 1));
        for (int j = 0; j < K; j++) tA[i][j][c] = worst ? Q - 1 : int'($urandom_range(0, Q - 1));
      end
  endtask

  task automatic drive_inputs();
    for (int i = 0; i < K; i++)
      for (int c = 0; c < 256; c++) begin
        s_in[i][c] = 12'(ts[i][c]);
        e_in[i][c] = 12'(te[i][c]);
        for (int j = 0; j < K; j++) a_in[i][j][c] = 12'(tA[i][j][c]);
      end
  endtask

  // t[i] = e[i] + sum_j BaseCaseMultiply(A[i][j] or A[j][i], s[j]) over 128 pairs
  task automatic model(input bit tr);
    for (int i = 0; i < K; i++)
      for (int c = 0; c < 256; c++) exp_t[i][c] = te[i][c];
    for (int i = 0; i < K; i++)
      for (int j = 0; j < K; j++)
        for (int k = 0; k < 128; k++) begin
          longint a0, a1, b0, b1, r0, r1;
          a0 = tr ? tA[j][i][2*k]   : tA[i][j][2*k];
          a1 = tr ? tA[j][i][2*k+1] : tA[i][j][2*k+1];
          b0 = ts[j][2*k];
          b1 = ts[j][2*k+1];
          r0 = (a0 * b0 + a1 * b1 * gam[k]) % Q;
          r1 = (a0 * b1 + a1 * b0) % Q;
          exp_t[i][2*k]   = int'((exp_t[i][2*k] + r0) % Q);
          exp_t[i][2*k+1] = int'((exp_t[i][2*k+1] + r1) % Q);
        end
  endtask

  task automatic compare_all(input string tag, input bit range_chk);
    for (int i = 0; i < K; i++)
      for (int c = 0; c < 256; c++) begin
        check_eq($sformatf("%s t[%0d][%0d]", tag, i, c), t_out[i][c], exp_t[i][c]);
        if (range_chk) check_eq($sformatf("%s range[%0d][%0d]", tag, i, c), (t_out[i][c] < Q), 1);
      end
  endtask

  task automatic run_op(input bit tr, input int pa, input int pb, input string tag, input bit range_chk);
    int cyc;
    drive_inputs();
    model(tr);
    @(negedge clk_i);
    run_i = 1'b1;
    transpose_i = tr;
    @(negedge clk_i);
    run_i = 1'b0;
    transpose_i = ~tr;
    for (int i = 0; i < K; i++)
      for (int c = 0; c < 256; c++) e_in[i][c] = 12'($urandom_range(0, Q - 1));
    check_eq({tag, " busy"}, busy_o, 1);
    cyc = 0;
    while (!done_o && cyc < 2000) begin
      @(negedge clk_i);
      cyc++;
      run_i = (cyc == pa || cyc == pb);
    end
    run_i = 1'b0;
    check_eq({tag, " latency"}, cyc, LAT);
    compare_all(tag, range_chk);
    @(negedge clk_i);
    check_eq({tag, " done_one_cycle"}, done_o, 0);
    check_eq({tag, " idle_after"}, busy_o, 0);
  endtask

  initial begin
    int ndone;
    for (int k = 0; k < 128; k++) begin
      int br, e, g;
      br = 0;
      for (int b = 0; b < 7; b++) if (((k >> b) & 1) != 0) br = br | (1 << (6 - b));
      e = 2 * br + 1;
      g = 1;
      for (int n = 0; n < e; n++) g = (g * 17) % Q;
      gam[k] = g;
    end

    rst_i = 1'b1;
    run_i = 1'b0;
    transpose_i = 1'b0;
    clear_vectors();
    drive_inputs();
    repeat (3) @(negedge clk_i);
    check_eq("reset busy", busy_o, 0);
    check_eq("reset done", done_o, 0);
    check_eq("reset out_zero", (t_out == '0), 1);
    rst_i = 1'b0;

    clear_vectors();
    for (int c = 0; c < 256; c++) ts[0][c] = int'($urandom_range(0, Q - 1));
    te[0][0] = 5;
    te[1][255] = Q - 1;
    run_op(1'b0, -1, -1, "e_only", 1'b0);
    check_eq("e_only t00", t_out[0][0], 5);
    check_eq("e_only t1_255", t_out[1][255], Q - 1);

    clear_vectors();
    tA[0][0][0] = 1; tA[0][0][1] = 1; ts[0][0] = 1; ts[0][1] = 1;
    run_op(1'b0, -1, -1, "pair0", 1'b0);
    check_eq("pair0 lit t00", t_out[0][0], 18);
    check_eq("pair0 lit t01", t_out[0][1], 2);

    clear_vectors();
    tA[0][0][2] = 1; tA[0][0][3] = 1; ts[0][2] = 1; ts[0][3] = 1;
    run_op(1'b0, -1, -1, "pair1", 1'b0);
    check_eq("pair1 lit t02", t_out[0][2], 3313);
    check_eq("pair1 lit t03", t_out[0][3], 2);

    clear_vectors();
    for (int c = 0; c < 256; c++) begin
      tA[0][1][c] = int'($urandom_range(0, Q - 1));
      ts[0][c] = int'($urandom_range(0, Q - 1));
      ts[1][c] = int'($urandom_range(0, Q - 1));
      te[0][c] = int'($urandom_range(0, Q - 1));
      te[1][c] = int'($urandom_range(0, Q - 1));
    end
    run_op(1'b0, -1, -1, "a01_plain", 1'b0);
    run_op(1'b1, -1, -1, "a01_trans", 1'b0);

    fill_vectors(1'b1);
    run_op(1'b0, -1, -1, "worst", 1'b1);

    for (int r = 0; r < 20; r++) begin
      fill_vectors(1'b0);
      if (r == 3) run_op(1'($urandom_range(0, 1)), 10, 200, "rand_runpulse", 1'b1);
      else run_op(1'($urandom_range(0, 1)), -1, -1, $sformatf("rand%0d", r), 1'b1);
    end

    fill_vectors(1'b0);
    drive_inputs();
    @(negedge clk_i);
    run_i = 1'b1;
    transpose_i = 1'b0;
    @(negedge clk_i);
    run_i = 1'b0;
    repeat (50) @(negedge clk_i);
    #2 rst_i = 1'b1;
    #1;
    check_eq("midrst busy", busy_o, 0);
    check_eq("midrst done", done_o, 0);
    check_eq("midrst out_zero", (t_out == '0), 1);
    @(negedge clk_i);
    rst_i = 1'b0;
    ndone = 0;
    repeat (LAT + 20) begin
      @(negedge clk_i);
      if (done_o) ndone++;
    end
    check_eq("midrst no_done", ndone, 0);
    run_op(1'b1, -1, -1, "after_rst", 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
